// File: rtl/pll_sup_pkg.sv
// PLL lock supervisor shared definitions.
// State encoding and counter sizing helpers.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        S_PLLRST = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Width holding 0 .. max(a,b,c)-1
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = max3(a, b, c);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL lock input.
// Both stages clear to 0 on reset so lock is never assumed.
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: qualifies lock, sequences PLL and system reset.
// Optional macro PLL_SUP_LOSS_COUNT_EN adds a saturating loss_count port.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter  int RST_CYCLES    = 16,
    parameter  int LOCK_TIMEOUT  = 65536,
    parameter  int STABLE_CYCLES = 1024,
    parameter  int LOSS_FILTER   = 4,
    parameter  int MAX_RETRY     = 7,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pll_lock,
    output logic          pll_rst,
    output logic          sys_reset_n,
    output logic          locked,
    output logic          fail,
`ifdef PLL_SUP_LOSS_COUNT_EN
    output logic [7:0]    loss_count,
`endif
    output logic [RW-1:0] retry_cnt
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int LW = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_FILTER - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    logic          lock_s;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          pll_rst_q, pll_rst_d;
    logic          run_q, run_d;
    logic          fail_q, fail_d;
    logic          loss_evt;

    pll_lock_sync u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Next state, counters, and outputs decoded from the next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        lcnt_d   = lcnt_q;
        retry_d  = retry_q;
        loss_evt = 1'b0;
        case (state_q)
            S_PLLRST: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TO_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_PLLRST;
                    end
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT;
                end else if (cnt_q == STB_LAST) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (lock_s) begin
                    lcnt_d = '0;
                end else if (lcnt_q == LOSS_LAST) begin
                    state_d  = S_PLLRST;
                    loss_evt = 1'b1;
                end else begin
                    lcnt_d = lcnt_q + LW'(1);
                end
            end
            S_FAIL: begin
                cnt_d = '0;
            end
            default: begin
                state_d = S_PLLRST;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d  = '0;
            lcnt_d = '0;
        end
        pll_rst_d = (state_d == S_PLLRST);
        run_d     = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_PLLRST;
            cnt_q     <= '0;
            lcnt_q    <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            run_q     <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lcnt_q    <= lcnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            run_q     <= run_d;
            fail_q    <= fail_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset_n = run_q;
    assign locked      = run_q;
    assign fail        = fail_q;
    assign retry_cnt   = retry_q;

`ifdef PLL_SUP_LOSS_COUNT_EN
    logic [7:0] loss_q, loss_d;

    // Saturating count of lock-loss events
    always_comb begin
        loss_d = loss_q;
        if (loss_evt && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
    end

    // Loss counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) loss_q <= 8'd0;
        else          loss_q <= loss_d;
    end

    assign loss_count = loss_q;
`else
    logic unused_loss;
    assign unused_loss = loss_evt;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor with an edge-timestamp reference model.
// Define PLL_SUP_LOSS_COUNT_EN to also check loss_count.
module tb_pll_lock_supervisor;

    localparam int RSTC = 8;
    localparam int TO   = 100;
    localparam int STB  = 16;
    localparam int LOSS = 4;
    localparam int MAXR = 2;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STB  = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       locked;
    logic       fail;
    logic [1:0] retry_cnt;
`ifdef PLL_SUP_LOSS_COUNT_EN
    logic [7:0] loss_count;
`endif

    int checks = 0;
    int failures = 0;

    // model
    int ecount, m_phase, m_enter, m_retry, m_low, m_loss;
    bit m_s1, m_s2;

    // observed events (edge numbers, -1 = none)
    int rise_sys, fall_sys, rise_rst, fall_rst, rise_fail, n_rst_fall;
    logic prev_sys, prev_rst, prev_fail;

    pll_lock_supervisor #(
        .RST_CYCLES    (RSTC),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (STB),
        .LOSS_FILTER   (LOSS),
        .MAX_RETRY     (MAXR)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_lock    (pll_lock),
        .pll_rst     (pll_rst),
        .sys_reset_n (sys_reset_n),
        .locked      (locked),
        .fail        (fail),
`ifdef PLL_SUP_LOSS_COUNT_EN
        .loss_count  (loss_count),
`endif
        .retry_cnt   (retry_cnt)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_ev();
        rise_sys = -1; fall_sys = -1;
        rise_rst = -1; fall_rst = -1;
        rise_fail = -1; n_rst_fall = 0;
    endtask

    task automatic enter(input int p);
        m_phase = p;
        m_enter = ecount;
        m_low   = 0;
    endtask

    // One clock edge of the behavioural model; lk is the sampled pll_lock
    task automatic model_step(input bit lk);
        bit ls;
        int el;
        ecount++;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        el   = ecount - m_enter;
        case (m_phase)
            P_RST:  if (el == RSTC) enter(P_WAIT);
            P_WAIT: begin
                if (ls) enter(P_STB);
                else if (el == TO) begin
                    if (m_retry == MAXR) enter(P_FAIL);
                    else begin
                        m_retry++;
                        enter(P_RST);
                    end
                end
            end
            P_STB: begin
                if (!ls) enter(P_WAIT);
                else if (el == STB) begin
                    m_retry = 0;
                    enter(P_RUN);
                end
            end
            P_RUN: begin
                m_low = ls ? 0 : m_low + 1;
                if (m_low == LOSS) begin
                    if (m_loss < 255) m_loss++;
                    enter(P_RST);
                end
            end
            default: ;
        endcase
    endtask

    task automatic step(input bit lk);
        pll_lock = lk;
        @(posedge clk);
        model_step(lk);
        @(negedge clk);
        chk("pll_rst", pll_rst, 32'(m_phase == P_RST));
        chk("sys_reset_n", sys_reset_n, 32'(m_phase == P_RUN));
        chk("locked", locked, 32'(m_phase == P_RUN));
        chk("fail", fail, 32'(m_phase == P_FAIL));
        chk("retry_cnt", retry_cnt, m_retry);
`ifdef PLL_SUP_LOSS_COUNT_EN
        chk("loss_count", loss_count, m_loss);
`endif
        if (sys_reset_n === 1'b1 && prev_sys === 1'b0) rise_sys = ecount;
        if (sys_reset_n === 1'b0 && prev_sys === 1'b1) fall_sys = ecount;
        if (pll_rst === 1'b1 && prev_rst === 1'b0) rise_rst = ecount;
        if (pll_rst === 1'b0 && prev_rst === 1'b1) begin
            fall_rst = ecount;
            n_rst_fall++;
        end
        if (fail === 1'b1 && prev_fail === 1'b0) rise_fail = ecount;
        prev_sys  = sys_reset_n;
        prev_rst  = pll_rst;
        prev_fail = fail;
    endtask

    task automatic run(input bit lk, input int n);
        for (int i = 0; i < n; i++) step(lk);
    endtask

    // Called at a falling clock edge; pulses reset_n mid-cycle
    task automatic async_reset(input string tag);
        #5 reset_n = 1'b0;
        #1;
        chk({tag, "_pll_rst"}, pll_rst, 1);
        chk({tag, "_sys_reset_n"}, sys_reset_n, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_fail"}, fail, 0);
        chk({tag, "_retry"}, retry_cnt, 0);
`ifdef PLL_SUP_LOSS_COUNT_EN
        chk({tag, "_loss"}, loss_count, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        ecount = 0; m_retry = 0; m_loss = 0;
        m_s1 = 0; m_s2 = 0;
        enter(P_RST);
        prev_sys = 0; prev_rst = 1; prev_fail = 0;
        clr_ev();
    endtask

    initial begin
        int k, j, n;
        pll_lock = 1'b0;
        @(negedge clk);

        // Reset, then a clean lock
        async_reset("por");
        run(0, RSTC + 20);
        chk("rst_pulse_fall", fall_rst, RSTC);
        k = ecount + 1;
        run(1, 20);
        chk("lock_rise_edge", rise_sys, k + 2 + STB);
        chk("lock_retry", retry_cnt, 0);

        // Short glitch ignored, then a real loss and relock
        clr_ev();
        run(0, LOSS - 1);
        run(1, 6);
        chk("glitch_no_fall", fall_sys, -1);
        j = ecount + 1;
        run(0, LOSS);
        run(1, 28);
        chk("loss_fall", fall_sys, j + 1 + LOSS);
        chk("loss_rst_rise", rise_rst, j + 1 + LOSS);
        chk("loss_rst_fall", fall_rst, j + 1 + LOSS + RSTC);
        chk("relock_rise", rise_sys, j + 1 + LOSS + RSTC + 1 + STB);
`ifdef PLL_SUP_LOSS_COUNT_EN
        chk("loss_count_1", loss_count, 1);
`endif

        // Random lock dropouts while running
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(1, 6);
            run(0, n);
            n = $urandom_range(1, 30);
            run(1, n);
        end

        // Unstable lock aborts qualification
        @(negedge clk);
        async_reset("unstable");
        run(0, RSTC + 5);
        run(1, 10);
        run(0, 3);
        k = ecount + 1;
        run(1, 20);
        chk("unstable_rise", rise_sys, k + 2 + STB);

        // Lock never arrives: retries then permanent failure
        @(negedge clk);
        async_reset("timeout");
        run(0, 330);
        chk("fail_edge", rise_fail, 3 * RSTC + 3 * TO);
        chk("rst_pulses", n_rst_fall, MAXR + 1);
        chk("fail_pll_rst", pll_rst, 0);
        chk("fail_flag", fail, 1);

        // Reset out of failure, then reset mid-qualification
        async_reset("in_fail");
        run(0, RSTC);
        run(1, 6);
        async_reset("in_stable");
        run(0, RSTC + 2);
        k = ecount + 1;
        run(1, 20);
        chk("restart_rise", rise_sys, k + 2 + STB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
